// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state encoding and default stall limit for the two-master Wishbone arbiter.
package wb_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/wb_arb_wdt.sv
// wb_arb_wdt: slave-stall counter that flags the cycle in which the stall limit is reached.
module wb_arb_wdt
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [7:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (inc) r_cnt <= r_cnt + 8'd1;
  end
  assign expired = r_cnt == 8'(TIMEOUT - 1);
endmodule

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: round-robin arbiter letting two Wishbone masters share one slave, with bus lock and stall timeout.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic        m0_we_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        s_we_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);
  state_t r_state, w_next;
  logic   r_owner, r_last;
  logic   w_req0, w_req1, w_req, w_pick, w_busy;
  logic   w_own_cyc, w_own_stb, w_stall, w_expired, w_timeout, w_leave;
  assign w_req0    = m0_cyc_i & m0_stb_i;
  assign w_req1    = m1_cyc_i & m1_stb_i;
  assign w_req     = w_req0 | w_req1;
  // on contention the master that did not own the bus last wins (1 = m1)
  assign w_pick    = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_busy    = r_state == BUSY;
  assign w_own_cyc = r_owner ? m1_cyc_i : m0_cyc_i;
  assign w_own_stb = r_owner ? m1_stb_i : m0_stb_i;
  assign w_stall   = w_busy & w_own_stb & ~s_ack_i;
  assign w_timeout = w_stall & w_expired;
  assign w_leave   = w_busy & (~w_own_cyc | w_timeout);
  wb_arb_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (~w_busy | ~w_own_stb | s_ack_i | w_leave),
    .inc     (w_stall),
    .expired (w_expired)
  );
  always_comb begin
    w_next = w_busy ? (w_leave ? IDLE : BUSY) : (w_req ? BUSY : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (!w_busy && w_req) r_owner <= w_pick;
      if (w_leave) r_last <= r_owner;
    end
  end
  always_comb begin
    s_adr_o  = w_busy ? (r_owner ? m1_adr_i : m0_adr_i) : '0;
    s_dat_o  = w_busy ? (r_owner ? m1_dat_i : m0_dat_i) : '0;
    s_we_o   = w_busy & (r_owner ? m1_we_i : m0_we_i);
    s_stb_o  = w_busy & w_own_stb;
    s_cyc_o  = w_busy & w_own_cyc;
    m0_ack_o = w_busy & ~r_owner & s_ack_i;
    m1_ack_o = w_busy & r_owner & s_ack_i;
    m0_err_o = ~r_owner & w_timeout;
    m1_err_o = r_owner & w_timeout;
    grant_o  = w_busy ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
  end
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed and randomized checks of wb_arbiter2 against a small GPIO-style slave and a rule-based reference.
module tb_wb_arbiter2;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       cyc = '0, stb = '0, we = '0;
  logic [1:0][31:0] adr = '0, wd = '0;
  logic [1:0][31:0] rd;
  logic [1:0]       ack, err, grant;
  logic [31:0]      s_adr, s_dat_o, s_dat_i;
  logic             s_we, s_stb, s_cyc, s_ack;
  logic [31:0]      mem [16];
  logic             ack_en = 1'b1;
  int               ack_dly = 0;
  int               scnt;
  int               tests = 0, fails = 0;
  int               exp_last = 1;
  logic [31:0]      refm [16];

  always #5 clk = ~clk;

  wb_arbiter2 #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_adr_i(adr[0]), .m0_dat_i(wd[0]), .m0_we_i(we[0]), .m0_stb_i(stb[0]), .m0_cyc_i(cyc[0]),
    .m0_dat_o(rd[0]), .m0_ack_o(ack[0]), .m0_err_o(err[0]),
    .m1_adr_i(adr[1]), .m1_dat_i(wd[1]), .m1_we_i(we[1]), .m1_stb_i(stb[1]), .m1_cyc_i(cyc[1]),
    .m1_dat_o(rd[1]), .m1_ack_o(ack[1]), .m1_err_o(err[1]),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_we_o(s_we), .s_stb_o(s_stb), .s_cyc_o(s_cyc),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .grant_o(grant)
  );

  // registered-ack slave: acks after ack_dly+1 stall cycles, mem[0] is the gpio output register
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack <= 1'b0;
      scnt  <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      s_ack <= s_cyc & s_stb & ~s_ack & ack_en & (scnt >= ack_dly);
      scnt  <= (s_cyc & s_stb & ~s_ack) ? scnt + 1 : 0;
      if (s_cyc & s_stb & s_we & s_ack) mem[s_adr[5:2]] <= s_dat_o;
    end
  end
  assign s_dat_i = mem[s_adr[5:2]];

  task automatic set_req(input int m, input bit c, input bit w, input logic [31:0] a, input logic [31:0] d);
    cyc[m] = c; stb[m] = c; we[m] = w; adr[m] = a; wd[m] = d;
  endtask

  task automatic wait_ack(input int m, output bit ok);
    int n = 0;
    while (ack[m] !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    ok = ack[m] === 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst_n = 1'b0;
    cyc = '0; stb = '0; we = '0;
    @(negedge clk) rst_n = 1'b1;
    exp_last = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({grant, s_cyc, s_stb, s_we, ack, err} !== '0 || s_adr !== '0 || s_dat_o !== '0)
      $display("FAIL reset_outputs: grant=%b cyc=%b stb=%b we=%b ack=%b err=%b adr=%h dat=%h, want all 0",
               grant, s_cyc, s_stb, s_we, ack, err, s_adr, s_dat_o);
    if ({grant, s_cyc, s_stb, s_we, ack, err} !== '0 || s_adr !== '0 || s_dat_o !== '0) fails++;
    rst_n = 1'b1;
    exp_last = 1;
  endtask

  task automatic test_single();
    bit ok;
    @(posedge clk); #1 set_req(0, 1, 1, 32'h0, 32'h0000_00A5);
    @(negedge clk);
    tests++;
    if (grant !== 2'b00) begin fails++; $display("FAIL single_lat0: grant=%b want 00", grant); end
    @(negedge clk);
    tests++;
    if (grant !== 2'b01) begin fails++; $display("FAIL single_grant: grant=%b want 01", grant); end
    tests++;
    if ({s_cyc, s_stb, s_we} !== 3'b111 || s_dat_o !== 32'hA5) begin
      fails++; $display("FAIL single_mux: cyc/stb/we=%b dat=%h want 111/a5", {s_cyc, s_stb, s_we}, s_dat_o);
    end
    wait_ack(0, ok);
    tests++;
    if (!ok || ack[1] !== 1'b0 || err !== 2'b00) begin
      fails++; $display("FAIL single_ack: ack=%b err=%b want ack=01 err=00", ack, err);
    end
    @(posedge clk); #1 set_req(0, 0, 0, 0, 0);
    @(negedge clk);
    tests++;
    if (mem[0] !== 32'hA5) begin fails++; $display("FAIL single_gpio: gpio_out=%h want a5", mem[0]); end
    @(negedge clk);
    tests++;
    if (grant !== 2'b00) begin fails++; $display("FAIL single_idle: grant=%b want 00", grant); end
    exp_last = 0;
  endtask

  task automatic test_contention();
    bit ok;
    int first, second;
    pulse_reset();
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      set_req(0, 1, 1, 32'h4, 32'h11 + r);
      set_req(1, 1, 1, 32'h8, 32'h22);
      first  = exp_last == 1 ? 0 : 1;
      second = 1 - first;
      @(negedge clk); @(negedge clk);
      tests++;
      if (grant !== 2'(1 << first)) begin
        fails++; $display("FAIL cont_first[%0d]: grant=%b want %b", r, grant, 2'(1 << first));
      end
      wait_ack(first, ok);
      tests++;
      if (!ok || ack[second] !== 1'b0) begin fails++; $display("FAIL cont_ack1[%0d]: ack=%b", r, ack); end
      @(posedge clk); #1 set_req(first, 0, 0, 0, 0);
      exp_last = first;
      @(negedge clk); @(negedge clk);
      tests++;
      if (grant !== 2'b00) begin fails++; $display("FAIL cont_gap[%0d]: grant=%b want 00", r, grant); end
      @(negedge clk);
      tests++;
      if (grant !== 2'(1 << second)) begin
        fails++; $display("FAIL cont_second[%0d]: grant=%b want %b", r, grant, 2'(1 << second));
      end
      wait_ack(second, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL cont_ack2[%0d]: ack=%b want bit %0d", r, ack, second); end
      @(posedge clk); #1 set_req(second, 0, 0, 0, 0);
      exp_last = second;
      @(negedge clk); @(negedge clk);
    end
  endtask

  task automatic test_lock();
    bit ok;
    @(posedge clk); #1 set_req(1, 1, 0, 32'h8, 0);
    @(negedge clk); @(negedge clk);
    tests++;
    if (grant !== 2'b10) begin fails++; $display("FAIL lock_grant: grant=%b want 10", grant); end
    @(posedge clk); #1 set_req(0, 1, 1, 32'hC, 32'h5A);
    for (int k = 0; k < 3; k++) begin
      wait_ack(1, ok);
      tests++;
      if (!ok || grant !== 2'b10 || rd[1] !== 32'h22 || ack[0] !== 1'b0) begin
        fails++; $display("FAIL lock_read[%0d]: ack=%b grant=%b data=%h want ack=10 grant=10 data=22", k, ack, grant, rd[1]);
      end
      @(posedge clk); #1;
      if (k == 2) set_req(1, 0, 0, 0, 0);
    end
    exp_last = 1;
    @(negedge clk); @(negedge clk);
    tests++;
    if (grant !== 2'b00) begin fails++; $display("FAIL lock_release: grant=%b want 00", grant); end
    @(negedge clk);
    tests++;
    if (grant !== 2'b01) begin fails++; $display("FAIL lock_m0_after: grant=%b want 01", grant); end
    wait_ack(0, ok);
    @(posedge clk); #1 set_req(0, 0, 0, 0, 0);
    exp_last = 0;
    @(negedge clk); @(negedge clk);
    tests++;
    if (!ok || mem[3] !== 32'h5A) begin fails++; $display("FAIL lock_m0_write: mem=%h want 5a", mem[3]); end
  endtask

  task automatic test_timeout();
    ack_en = 1'b0;
    @(posedge clk); #1 set_req(0, 1, 0, 32'h0, 0);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      tests++;
      if (err !== (k == 4 ? 2'b01 : 2'b00) || ack !== 2'b00) begin
        fails++; $display("FAIL timeout_err[%0d]: err=%b ack=%b want err=%b ack=00", k, err, ack, k == 4 ? 2'b01 : 2'b00);
      end
    end
    @(posedge clk); #1 set_req(0, 0, 0, 0, 0);
    exp_last = 0;
    @(negedge clk);
    tests++;
    if ({s_cyc, s_stb} !== 2'b00 || grant !== 2'b00 || err !== 2'b00) begin
      fails++; $display("FAIL timeout_idle: cyc/stb=%b grant=%b err=%b want 00/00/00", {s_cyc, s_stb}, grant, err);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_ack_precedence();
    ack_dly = 2;
    @(posedge clk); #1 set_req(1, 1, 1, 32'h18, 32'h33);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      tests++;
      if (ack !== (k == 4 ? 2'b10 : 2'b00) || err !== 2'b00) begin
        fails++; $display("FAIL ack_prec[%0d]: ack=%b err=%b want ack=%b err=00", k, ack, err, k == 4 ? 2'b10 : 2'b00);
      end
    end
    @(posedge clk); #1 set_req(1, 0, 0, 0, 0);
    exp_last = 1;
    ack_dly = 0;
    @(negedge clk); @(negedge clk);
    tests++;
    if (mem[6] !== 32'h33 || grant !== 2'b00) begin
      fails++; $display("FAIL ack_prec_write: mem=%h grant=%b want 33/00", mem[6], grant);
    end
  endtask

  task automatic test_abort();
    logic [1:0] seen = '0;
    ack_en = 1'b0;
    @(posedge clk); #1 set_req(0, 1, 1, 32'h10, 32'hFF);
    @(negedge clk); @(negedge clk);
    tests++;
    if (grant !== 2'b01) begin fails++; $display("FAIL abort_grant: grant=%b want 01", grant); end
    @(negedge clk);
    seen = ack | err;
    @(posedge clk); #1 set_req(0, 0, 0, 0, 0);
    ack_en = 1'b1;
    @(negedge clk);
    seen = seen | ack | err;
    @(negedge clk);
    tests++;
    if (grant !== 2'b00) begin fails++; $display("FAIL abort_idle: grant=%b want 00", grant); end
    tests++;
    if (seen !== 2'b00 || mem[4] !== 32'h0) begin
      fails++; $display("FAIL abort_noack: ack|err=%b mem=%h want 00/0", seen, mem[4]);
    end
    exp_last = 0;
  endtask

  task automatic test_reset_mid();
    logic [5:0] seen = '0;
    @(posedge clk); #1 set_req(1, 1, 1, 32'h14, 32'h77);
    @(negedge clk); @(negedge clk);
    tests++;
    if (grant !== 2'b10) begin fails++; $display("FAIL rst_mid_grant: grant=%b want 10", grant); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({grant, s_cyc, s_stb, s_we, ack, err} !== '0 || s_adr !== '0 || s_dat_o !== '0) begin
      fails++; $display("FAIL rst_mid_outputs: grant=%b cyc=%b stb=%b ack=%b err=%b adr=%h, want all 0",
                        grant, s_cyc, s_stb, ack, err, s_adr);
    end
    set_req(1, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    exp_last = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen = seen | {grant, ack, err};
    end
    tests++;
    if (seen !== '0) begin fails++; $display("FAIL rst_noack: grant|ack|err seen=%b want 0", seen); end
  endtask

  task automatic test_random();
    int left[2], gap[2], wait_n[2], done_n[2];
    bit done[2];
    logic [1:0] prev_g = '0, prev_req = '0, last_g = 2'b10, exp_g;
    int idx;
    for (int i = 0; i < 16; i++) refm[i] = '0;
    for (int m = 0; m < 2; m++) begin left[m] = 0; gap[m] = m; wait_n[m] = 0; done_n[m] = 0; end
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      tests++;
      if ((grant & (grant - 2'b01)) != 2'b00 || (ack & ~grant) != 2'b00 || err !== 2'b00) begin
        fails++; $display("FAIL rand_bus[%0d]: grant=%b ack=%b err=%b", c, grant, ack, err);
      end
      if (prev_g == 2'b00 && grant != 2'b00 && prev_req == 2'b11) begin
        exp_g = last_g == 2'b10 ? 2'b01 : 2'b10;
        tests++;
        if (grant !== exp_g) begin fails++; $display("FAIL rand_rr[%0d]: grant=%b want %b", c, grant, exp_g); end
      end
      if (prev_g != 2'b00 && grant == 2'b00) last_g = prev_g;
      for (int m = 0; m < 2; m++) begin
        done[m] = cyc[m] & stb[m] & ack[m];
        if (done[m]) begin
          idx = int'(adr[m][5:2]);
          if (we[m]) refm[idx] = wd[m];
          else begin
            tests++;
            if (rd[m] !== refm[idx]) begin
              fails++; $display("FAIL rand_read[%0d] m%0d idx %0d: data=%h want %h", c, m, idx, rd[m], refm[idx]);
            end
          end
          tests++;
          if (wait_n[m] > 20) begin fails++; $display("FAIL rand_starve m%0d: waited %0d want <=20", m, wait_n[m]); end
          left[m]--;
          done_n[m]++;
        end else if (cyc[m]) wait_n[m]++;
      end
      prev_req = cyc & stb;
      prev_g   = grant;
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        if (done[m] && left[m] == 0) begin
          set_req(m, 0, 0, 0, 0);
          gap[m] = $urandom_range(0, 3);
        end else if (done[m] || (!cyc[m] && gap[m] == 0)) begin
          if (!cyc[m]) left[m] = $urandom_range(1, 3);
          set_req(m, 1, 1'($urandom_range(0, 1)), 32'((m * 8 + $urandom_range(0, 7)) << 2), $urandom);
          wait_n[m] = 0;
        end else if (!cyc[m]) gap[m]--;
      end
    end
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    tests++;
    if (done_n[0] < 50 || done_n[1] < 50) begin
      fails++; $display("FAIL rand_progress: m0=%0d m1=%0d completions want >=50 each", done_n[0], done_n[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_timeout();
    test_ack_precedence();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
